// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl shared types
// Trigger mode codes, FSM states, default widths.
package adc_capture_ctrl_pkg;

  localparam int ADC_PRECISION = 10;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'b00,
    TRIG_RISING    = 2'b01,
    TRIG_FALLING   = 2'b10,
    TRIG_EXTERNAL  = 2'b11
  } trig_mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_e;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl FIFO write port
// Master drives data/strobe, FIFO returns full.
interface adc_capture_ctrl_if
  import adc_capture_ctrl_pkg::*;
#(
  parameter int W = ADC_PRECISION
);
  logic [W-1:0] fifo_din;
  logic         fifo_wr_en;
  logic         fifo_full;

  modport master (
    output fifo_din,
    output fifo_wr_en,
    input  fifo_full
  );

  modport slave (
    input  fifo_din,
    input  fifo_wr_en,
    output fifo_full
  );
endinterface

// File: rtl/adc_trigger_detect.sv
// adc_trigger_detect
// ext_trig synchroniser, edge detect, level compare.
module adc_trigger_detect
  import adc_capture_ctrl_pkg::*;
#(
  parameter int PRECISION = ADC_PRECISION
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           trig_mode,
  input  logic [PRECISION-1:0] trig_level,
  input  logic [PRECISION-1:0] code_q,
  input  logic [PRECISION-1:0] code_qq,
  input  logic                 ext_trig,
  output logic                 trig_hit
);

  // [0],[1] synchroniser; [2] previous synced value
  logic [2:0] ext_q;
  logic       ext_rise;

  // two-flop synchroniser plus one history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= '0;
    end else begin
      ext_q <= {ext_q[1:0], ext_trig};
    end
  end

  assign ext_rise = ext_q[1] & ~ext_q[2];

  // select the condition for the current mode
  always_comb begin
    trig_hit = 1'b0;
    unique case (trig_mode_e'(trig_mode))
      TRIG_IMMEDIATE: trig_hit = 1'b1;
      TRIG_RISING:
        trig_hit = (code_qq < trig_level) &&
                   (code_q >= trig_level);
      TRIG_FALLING:
        trig_hit = (code_qq > trig_level) &&
                   (code_q <= trig_level);
      TRIG_EXTERNAL:  trig_hit = ext_rise;
    endcase
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Arm/trigger FSM feeding decimated bursts to the FIFO.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int PRECISION   = ADC_PRECISION,
  parameter int COUNT_WIDTH = 16,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PRECISION-1:0]   adc_code_in,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [1:0]             trig_mode,
  input  logic [PRECISION-1:0]   trig_level,
  input  logic                   ext_trig,
  input  logic [COUNT_WIDTH-1:0] num_samples,
  input  logic [DECIM_WIDTH-1:0] decim,
  adc_capture_ctrl_if.master     fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] sample_count
);

  state_e                 state_q;
  logic [PRECISION-1:0]   code_q;
  logic [PRECISION-1:0]   code_qq;
  logic [DECIM_WIDTH-1:0] dcnt_q;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [COUNT_WIDTH-1:0] num_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   ovf_q;
  logic [PRECISION-1:0]   din_q;
  logic                   wr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   trig_hit;
  logic                   eligible;
  logic                   burst_end;

  // two-stage code pipeline for the level comparators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      code_qq <= '0;
    end else begin
      code_q  <= adc_code_in;
      code_qq <= code_q;
    end
  end

  adc_trigger_detect #(
    .PRECISION (PRECISION)
  ) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .code_q     (code_q),
    .code_qq    (code_qq),
    .ext_trig   (ext_trig),
    .trig_hit   (trig_hit)
  );

  assign eligible  = (dcnt_q == '0);
  // last write is on the bus this cycle: stop issuing more
  assign burst_end = (num_q != '0) && (cnt_q == num_q);

  // FSM with counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      decim_q <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (arm && !abort) begin
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dcnt_q  <= '0;
            num_q   <= num_samples;
            decim_q <= decim;
          end
        end
        S_ARMED: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (trig_hit) begin
            state_q <= S_CAPTURE;
            dcnt_q  <= '0;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (burst_end) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            dcnt_q <= (dcnt_q == decim_q) ? '0
                                          : dcnt_q + 1'b1;
            if (eligible) begin
              if (fifo.fifo_full) begin
                ovf_q <= 1'b1;
              end else begin
                wr_q  <= 1'b1;
                din_q <= code_q;
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else if (arm) begin
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dcnt_q  <= '0;
            num_q   <= num_samples;
            decim_q <= decim;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo.fifo_din   = din_q;
  assign fifo.fifo_wr_en = wr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign overflow        = ovf_q;
  assign sample_count    = cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl
// Directed bursts; FIFO writes checked against a queue.
module tb_adc_capture_ctrl;
  import adc_capture_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  adc;
  logic        arm, abort, ext;
  logic [1:0]  mode;
  logic [9:0]  level;
  logic [15:0] num;
  logic [7:0]  dec;
  logic        busy, done, ovf;
  logic [15:0] cnt;
  logic [9:0]  v0;
  bit          ramp;

  int          checks = 0;
  int          failures = 0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  adc_capture_ctrl_if #(.W(10)) fbus ();

  adc_capture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_code_in  (adc),
    .arm          (arm),
    .abort        (abort),
    .trig_mode    (mode),
    .trig_level   (level),
    .ext_trig     (ext),
    .num_samples  (num),
    .decim        (dec),
    .fifo         (fbus),
    .busy         (busy),
    .done         (done),
    .overflow     (ovf),
    .sample_count (cnt)
  );

  // monitor: every write must match the head of the queue
  always @(negedge clk) begin
    logic [9:0] e;
    if (fbus.fifo_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got=%h want=none",
                 fbus.fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (fbus.fifo_din !== e) begin
          failures++;
          $display("FAIL wr_data got=%h want=%h",
                   fbus.fifo_din, e);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // advance one edge; ramp changes just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp) adc = adc + 10'd1;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic push_ramp(input int k);
    exp_q.push_back(v0 + 10'(k));
  endtask

  initial begin
    rst_n = 1'b0; adc = '0; arm = 0; abort = 0;
    ext = 0; mode = 2'b00; level = '0; num = '0;
    dec = '0; ramp = 0; fbus.fifo_full = 1'b0;
    #12;
    chk("rst_wr", {31'd0, fbus.fifo_wr_en}, 0);
    chk("rst_din", {22'd0, fbus.fifo_din}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_cnt", {16'd0, cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: immediate, 4 samples; first code is the one
    // present at the edge after arm is sampled
    ramp = 1; mode = 2'b00; num = 16'd4; dec = 8'd0;
    arm = 1; v0 = adc;
    for (int i = 1; i <= 4; i++) push_ramp(i);
    tick(); arm = 0;
    chk("t1_busy", {31'd0, busy}, 1);
    wait_done("t1", 20);
    chk("t1_wr_in_done", {31'd0, fbus.fifo_wr_en}, 0);
    chk("t1_busy_end", {31'd0, busy}, 0);
    chk("t1_cnt", {16'd0, cnt}, 4);
    tick();
    chk("t1_q", exp_q.size(), 0);

    // 2: rising level 0x200; falling step must not fire
    ramp = 0; adc = 10'h300; mode = 2'b01;
    level = 10'h200; num = 16'd2;
    repeat (3) tick();
    arm = 1; tick(); arm = 0;
    adc = 10'h100;
    repeat (4) tick();
    chk("t2_armed", {31'd0, busy}, 1);
    chk("t2_cnt0", {16'd0, cnt}, 0);
    exp_q.push_back(10'h200);
    exp_q.push_back(10'h200);
    adc = 10'h1FF;
    repeat (2) tick();
    adc = 10'h200;
    wait_done("t2", 20);
    chk("t2_cnt", {16'd0, cnt}, 2);

    // 3: decim=3 -> codes k, k+4, k+8
    ramp = 1; mode = 2'b00; num = 16'd3; dec = 8'd3;
    arm = 1; v0 = adc;
    push_ramp(1); push_ramp(5); push_ramp(9);
    tick(); arm = 0;
    dec = 8'd0; num = 16'd1;
    wait_done("t3", 40);
    chk("t3_cnt", {16'd0, cnt}, 3);

    // 4: full for 5 edges drops v0+2..v0+6
    num = 16'd6; dec = 8'd0;
    arm = 1; v0 = adc;
    push_ramp(1);
    for (int i = 7; i <= 11; i++) push_ramp(i);
    tick(); arm = 0;
    tick(); tick();
    fbus.fifo_full = 1'b1;
    tick();
    chk("t4_ovf_set", {31'd0, ovf}, 1);
    repeat (4) tick();
    fbus.fifo_full = 1'b0;
    wait_done("t4", 30);
    chk("t4_ovf_sticky", {31'd0, ovf}, 1);
    chk("t4_cnt", {16'd0, cnt}, 6);

    // 5: abort after 2 writes, then re-arm clears
    num = 16'd10;
    arm = 1; v0 = adc;
    push_ramp(1); push_ramp(3);
    tick(); arm = 0;
    tick(); tick();
    fbus.fifo_full = 1'b1;
    tick();
    fbus.fifo_full = 1'b0;
    tick();
    abort = 1; tick(); abort = 0;
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_done", {31'd0, done}, 0);
    chk("t5_wr", {31'd0, fbus.fifo_wr_en}, 0);
    chk("t5_cnt", {16'd0, cnt}, 2);
    chk("t5_ovf", {31'd0, ovf}, 1);
    mode = 2'b11;
    arm = 1; tick(); arm = 0;
    chk("t5_rearm_cnt", {16'd0, cnt}, 0);
    chk("t5_rearm_ovf", {31'd0, ovf}, 0);
    repeat (3) tick();
    chk("t5_ext_wait", {31'd0, busy}, 1);
    abort = 1; tick(); abort = 0;
    chk("t5_abort_arm", {31'd0, busy}, 0);

    // 6: async reset mid-burst, then external trigger
    mode = 2'b00; num = 16'd8;
    arm = 1; v0 = adc;
    push_ramp(1); push_ramp(2);
    tick(); arm = 0;
    tick(); tick(); tick();
    @(negedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_cnt", {16'd0, cnt}, 0);
    chk("t6_rst_wr", {31'd0, fbus.fifo_wr_en}, 0);
    chk("t6_rst_din", {22'd0, fbus.fifo_din}, 0);
    tick();
    rst_n = 1'b1;
    ramp = 0; adc = 10'h155; mode = 2'b11; num = 16'd1;
    arm = 1; tick(); arm = 0;
    chk("t6_arm_first", {31'd0, busy}, 1);
    repeat (3) tick();
    chk("t6_no_trig", {31'd0, busy}, 1);
    exp_q.push_back(10'h155);
    ext = 1;
    wait_done("t6", 20);
    chk("t6_cnt", {16'd0, cnt}, 1);
    ext = 0;

    repeat (3) tick();
    chk("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
